// File: rtl/loc_link_pkg.sv
// Shared definitions for the camera_loc board-to-board link: field widths,
// word tags, FSM states, and the word/checksum builders shared with the receiver.
package loc_link_pkg;

  localparam int ANGLE_W   = 9;
  localparam int COORD_W   = 7;
  localparam int LOC_W     = 30;
  localparam int WORD_W    = 11;
  localparam int NUM_WORDS = 4;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [1:0]        TAG_START = 2'b11;
  localparam logic [1:0]        TAG_MID   = 2'b01;
  localparam logic [1:0]        TAG_END   = 2'b10;
  localparam logic [WORD_W-1:0] IDLE_WORD = '0;

  typedef enum logic {IDLE, SEND} state_t;

  // Two parity bits carried in the end word: bit0 covers angle/x, bit1 covers y/z.
  function automatic logic [1:0] chk(input logic [ANGLE_W-1:0] angle,
                                     input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y,
                                     input logic [COORD_W-1:0] z);
    return {(^y) ^ (^z), (^angle) ^ (^x)};
  endfunction

  // Word idx of the frame carrying loc.
  function automatic logic [WORD_W-1:0] make_word(input logic [LOC_W-1:0] loc,
                                                  input logic [IDX_W-1:0] idx);
    logic [ANGLE_W-1:0] a;
    logic [COORD_W-1:0] x, y, z;
    a = loc[LOC_W-1 -: ANGLE_W];
    x = loc[3*COORD_W-1 -: COORD_W];
    y = loc[2*COORD_W-1 -: COORD_W];
    z = loc[COORD_W-1:0];
    case (idx)
      2'd0:    return {TAG_START, a};
      2'd1:    return {TAG_MID, 2'b00, x};
      2'd2:    return {TAG_MID, 2'b00, y};
      default: return {TAG_END, chk(a, x, y, z), z};
    endcase
  endfunction

endpackage

// File: rtl/link_sync.sv
// N-stage synchroniser for one asynchronous handshake line. EDGE selects
// whether q is the synchronised level or a registered one-cycle rising-edge pulse.
module link_sync #(
  parameter int N    = 2,
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;

  // Shift the async input through the metastability chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[N-2:0], d};
  end

  generate
    if (EDGE) begin : g_edge
      logic prev_q, rise_q;
      // Registered rising-edge detect on the synchronised level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          prev_q <= sync_q[N-1];
          rise_q <= sync_q[N-1] & ~prev_q;
        end
      end
      assign q = rise_q;
    end else begin : g_level
      assign q = sync_q[N-1];
    end
  endgenerate

endmodule

// File: rtl/loc_link_tx.sv
// Tracking-board side of the PMOD link: latest-wins capture of camera_loc,
// then a 4-word framed burst paced by the receiver's ack clock and gated by
// its lock. The receiver must run link_clk_in no faster than one period per
// 2*(SYNC_STAGES+2) clk cycles so each word is stable when it samples.
module loc_link_tx
  import loc_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ABORT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [LOC_W-1:0]   camera_loc,
  input  logic               link_lock_in,
  input  logic               link_clk_in,
  output logic [WORD_W-1:0]  link_data_out,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic [ABORT_W-1:0] abort_count_out
);

  logic               ack, lock;
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LOC_W-1:0]   pend_q, frame_q;
  logic               pend_vld_q;
  logic               load, done_d, abort;
  logic               done_q;
  logic [ABORT_W-1:0] abort_cnt_q;

  link_sync #(.N(SYNC_STAGES), .EDGE(1'b1)) u_ack_sync (
    .clk(clk), .rst_n(rst_n), .d(link_clk_in), .q(ack)
  );

  link_sync #(.N(SYNC_STAGES), .EDGE(1'b0)) u_lock_sync (
    .clk(clk), .rst_n(rst_n), .d(link_lock_in), .q(lock)
  );

  // One-entry pending slot: new data always wins; consumption only clears the
  // flag when no new sample arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else if (valid_in) begin
      pend_q     <= camera_loc;
      pend_vld_q <= 1'b1;
    end else if (load) begin
      pend_vld_q <= 1'b0;
    end
  end

  // Frame snapshot is taken from the old pending value when a frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    frame_q <= '0;
    else if (load) frame_q <= pend_q;
  end

  // Next state: lock loss beats ack, ack in IDLE is ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    done_d  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (lock && pend_vld_q) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!lock) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (ack) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = IDX_W'(idx_q + 1'b1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, word index and the frame-done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Saturating count of frames dropped by lock loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            abort_cnt_q <= '0;
    else if (abort && (abort_cnt_q != '1)) abort_cnt_q <= ABORT_W'(abort_cnt_q + 1'b1);
  end

  assign link_data_out   = (state_q == SEND) ? make_word(frame_q, idx_q) : IDLE_WORD;
  assign busy_out        = (state_q == SEND);
  assign frame_done_out  = done_q;
  assign abort_count_out = abort_cnt_q;

endmodule

// File: tb/tb_loc_link_tx.sv
// Directed + randomized bench for loc_link_tx. Expected words come from a
// field-level model of the frame format; link_clk_in is driven with a
// 16-cycle period.
module tb_loc_link_tx;

  localparam int SYNC = 2;
  localparam int AW   = 8;

  logic          clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0;
  logic          link_lock_in = 1'b0, link_clk_in = 1'b0;
  logic [29:0]   camera_loc = '0;
  logic [10:0]   link_data_out;
  logic          busy_out, frame_done_out;
  logic [AW-1:0] abort_count_out;

  int n_pass = 0, n_total = 0, done_cnt = 0;

  loc_link_tx #(.SYNC_STAGES(SYNC), .ABORT_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .camera_loc(camera_loc),
    .link_lock_in(link_lock_in), .link_clk_in(link_clk_in),
    .link_data_out(link_data_out), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .abort_count_out(abort_count_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done_out) done_cnt <= done_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Reference: word i of a frame, built straight from the field layout.
  function automatic logic [10:0] exp_word(input logic [29:0] loc, input int i);
    logic [8:0] ang;
    logic [6:0] x, y, z;
    int c0, c1;
    ang = loc[29:21]; x = loc[20:14]; y = loc[13:7]; z = loc[6:0];
    c0 = ($countones(ang) + $countones(x)) % 2;
    c1 = ($countones(y) + $countones(z)) % 2;
    case (i)
      0:       return {2'b11, ang};
      1:       return {4'b0100, x};
      2:       return {4'b0100, y};
      default: return {2'b10, c1[0], c0[0], z};
    endcase
  endfunction

  function automatic logic [29:0] mk(input int a, input int x, input int y, input int z);
    return {a[8:0], x[6:0], y[6:0], z[6:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic post(input logic [29:0] loc);
    camera_loc = loc;
    valid_in   = 1'b1;
    tick(1);
    valid_in   = 1'b0;
  endtask

  task automatic ack();
    link_clk_in = 1'b1; tick(8);
    link_clk_in = 1'b0; tick(8);
  endtask

  task automatic wait_bus(output bit seen, input int lim);
    seen = 1'b0;
    for (int k = 0; k < lim; k++) begin
      tick(1);
      if (link_data_out != 11'h000) begin seen = 1'b1; break; end
    end
  endtask

  // Post into an idle, locked link: bus still idle, then W0 one edge later.
  task automatic start_frame(input logic [29:0] loc, input string tag);
    post(loc);
    check({tag, " pre_w0_idle"}, link_data_out, 11'h000);
    tick(1);
    check({tag, " w0"}, link_data_out, exp_word(loc, 0));
    check({tag, " busy"}, busy_out, 1'b1);
  endtask

  // Ack the final word: expect one done pulse with the bus returning to idle.
  task automatic last_ack(input string tag);
    int d0;
    bit found;
    d0 = done_cnt; found = 1'b0;
    link_clk_in = 1'b1;
    for (int k = 0; k < SYNC + 4; k++) begin
      tick(1);
      if (frame_done_out) begin found = 1'b1; break; end
    end
    check({tag, " done_seen"}, found, 1'b1);
    check({tag, " gap_bus"}, link_data_out, 11'h000);
    check({tag, " gap_busy"}, busy_out, 1'b0);
    tick(1);
    link_clk_in = 1'b0;
    tick(8);
    check({tag, " one_pulse"}, done_cnt - d0, 1);
  endtask

  task automatic finish_frame(input logic [29:0] loc, input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s w%0d", tag, i), link_data_out, exp_word(loc, i));
      ack();
    end
    check({tag, " w3"}, link_data_out, exp_word(loc, 3));
    check({tag, " busy_w3"}, busy_out, 1'b1);
    last_ack(tag);
  endtask

  initial begin
    logic [29:0] loc_a, loc_b, loc_90, loc_r;
    bit seen;
    int d0, miss;

    // Reset state
    tick(3);
    check("rst bus", link_data_out, 11'h000);
    check("rst busy", busy_out, 1'b0);
    check("rst done", frame_done_out, 1'b0);
    check("rst abort", abort_count_out, 8'd0);
    rst_n = 1'b1;
    link_lock_in = 1'b1;
    tick(4);

    // Basic frame with latest-wins posts during it
    start_frame(mk(180, 50, 0, 0), "basic");
    check("basic w0 const", link_data_out, 11'h6B4);
    post(mk(40, 3, 4, 5));
    loc_90 = mk(90, 0, 0, 0);
    post(loc_90);
    check("basic w0 stable", link_data_out, 11'h6B4);
    ack(); check("basic w1 const", link_data_out, 11'h232);
    ack(); check("basic w2 const", link_data_out, 11'h200);
    ack(); check("basic w3 const", link_data_out, 11'h480);
    last_ack("basic");
    check("latest w0 const", link_data_out, 11'h65A);
    finish_frame(loc_90, "latest");
    check("latest then idle", link_data_out, 11'h000);

    // Lock gating
    link_lock_in = 1'b0;
    tick(6);
    loc_r = 30'($urandom);
    post(loc_r);
    tick(4);
    check("nolock bus", link_data_out, 11'h000);
    check("nolock busy", busy_out, 1'b0);
    link_lock_in = 1'b1;
    wait_bus(seen, SYNC + 2);
    check("lock w0 latency", seen, 1'b1);
    finish_frame(loc_r, "lockgate");

    // Abort after the W1 ack, then restart with fresh data
    loc_a = 30'($urandom);
    start_frame(loc_a, "abortA");
    ack(); check("abortA w1", link_data_out, exp_word(loc_a, 1));
    ack();
    d0 = done_cnt;
    link_lock_in = 1'b0;
    tick(4);
    check("abort bus", link_data_out, 11'h000);
    check("abort busy", busy_out, 1'b0);
    check("abort cnt1", abort_count_out, 8'd1);
    check("abort no done", done_cnt - d0, 0);
    loc_b = 30'($urandom);
    post(loc_b);
    link_lock_in = 1'b1;
    wait_bus(seen, SYNC + 2);
    check("restart seen", seen, 1'b1);
    finish_frame(loc_b, "restart");

    // Ack and lock loss together on W3: abort wins
    loc_a = 30'($urandom);
    start_frame(loc_a, "simul");
    ack(); ack(); ack();
    check("simul w3", link_data_out, exp_word(loc_a, 3));
    d0 = done_cnt;
    link_clk_in = 1'b1; link_lock_in = 1'b0;
    tick(8);
    link_clk_in = 1'b0;
    tick(8);
    check("simul no done", done_cnt - d0, 0);
    check("simul cnt2", abort_count_out, 8'd2);
    check("simul bus", link_data_out, 11'h000);

    // Saturation: 258 more aborts (260 total)
    miss = 0;
    for (int n = 0; n < 258; n++) begin
      post(30'($urandom));
      link_lock_in = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < SYNC + 4; k++) begin
        tick(1);
        if (busy_out) begin seen = 1'b1; break; end
      end
      if (!seen) miss++;
      link_lock_in = 1'b0;
      tick(5);
    end
    check("sat frames started", miss, 0);
    check("sat abort cnt", abort_count_out, 8'd255);

    // Checksum boundary: x = -1
    link_lock_in = 1'b1;
    tick(4);
    loc_a = mk(0, 7'h7F, 1, 0);
    start_frame(loc_a, "chk");
    check("chk w0 const", link_data_out, 11'h600);
    ack(); ack(); ack();
    check("chk w3 const", link_data_out, 11'h580);
    last_ack("chk");

    // Async reset while W2 is on the bus
    loc_a = 30'($urandom);
    start_frame(loc_a, "rstmid");
    ack(); ack();
    check("rstmid w2", link_data_out, exp_word(loc_a, 2));
    rst_n = 1'b0;
    #1;
    check("rstmid bus", link_data_out, 11'h000);
    check("rstmid busy", busy_out, 1'b0);
    check("rstmid done", frame_done_out, 1'b0);
    check("rstmid abort", abort_count_out, 8'd0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    d0 = done_cnt;
    ack(); ack(); ack();
    check("postrst bus", link_data_out, 11'h000);
    check("postrst busy", busy_out, 1'b0);
    check("postrst no done", done_cnt - d0, 0);
    loc_b = 30'($urandom);
    start_frame(loc_b, "postrst");
    finish_frame(loc_b, "postrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
